alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one 32-bit ALU between two requesters with round-robin arbitration and a valid/ready request handshake.
- Latches the winning operands and drives the ALU, including the derived B_invert/carry_in controls.
- Waits a parameterised ALU latency, then returns the result and flags as a one-cycle tagged response.
- Sits between the ALU and its clients (e.g. the decode and address-generation paths).

Parameters:
- WIDTH, 32, datapath width of operands and result.
- ALU_LAT, 1, clock edges from stable ALU inputs to valid ALU outputs; 0 means a combinational ALU; range 0..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; a handshake occurs when valid[i] & ready[i] at a rising edge.
- req_op0, req_op1  in  3 each  operation code.
- req_a0, req_a1, req_b0, req_b1  in  WIDTH each  operands.
- alu_operation  out  3  to the ALU.
- alu_a, alu_b  out  WIDTH  to the ALU.
- alu_b_invert, alu_carry_in  out  1  to the ALU.
- alu_c  in  WIDTH  ALU result.
- alu_zero, alu_overflow, alu_carry_out  in  1  ALU flags.
- rsp_valid  out  1  one-cycle response strobe; no backpressure.
- rsp_id  out  1  index of the requester that owns the response.
- rsp_c  out  WIDTH  captured result.
- rsp_zero, rsp_overflow, rsp_carry  out  1  captured flags.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, priority pointer=0.
  - All outputs 0, including alu_* and rsp_*.
  - An in-flight operation is dropped and no response is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: one-hot to the granted requester, 0 if none valid.
  - Grant rule: if exactly one req_valid is set, that requester is granted. If both are set, the priority-pointer requester is granted.
  - On handshake (edge E0):
    - latch op/a/b into the alu_* registers;
    - alu_b_invert = alu_carry_in = op[2];
    - record rsp_id; set cnt=0; state -> WAIT;
    - pointer <- the other requester.
- WAIT:
  - req_ready=0; alu_* outputs are held stable; cnt increments each edge.
  - When cnt==ALU_LAT at an edge, capture alu_c/alu_zero/alu_overflow/alu_carry_out into rsp_*. Set rsp_valid=1 and state -> RESP.
  - Net latency: rsp_valid is high in the cycle after edge E0+ALU_LAT+1. With ALU_LAT=0 it is high in the cycle after E1.
- RESP:
  - rsp_valid=1 for exactly one cycle, then state -> IDLE and rsp_valid=0.
  - rsp_c and the flags hold their values until the next capture.
- Throughput: at most one operation per ALU_LAT+3 cycles; there is no grant in WAIT or RESP.
- Requesters must hold req_valid and payload stable until handshake. Dropping valid before a grant is legal and cancels the request.
- cnt width is 3 bits and never wraps, because ALU_LAT <= 7.
- An op code outside the package list is passed through unchanged; B_invert still follows op[2].

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110, OP_SLT=3'b111;
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the WIDTH default.
- One natural sub-module, rr_arbiter2: 2-way round-robin grant plus pointer update on accept.

Test Plan:
- Single request, ALU_LAT=1: requester 0 sends OP_ADD, a=5, b=7 at E0 -> alu_b_invert=0 and rsp_valid in the cycle after E2 with rsp_id=0, rsp_c=12, rsp_zero=0.
- OP_SUB with a=b=32'hFFFFFFFF from requester 1 -> alu_b_invert=1, alu_carry_in=1, rsp_c=0, rsp_zero=1, rsp_id=1.
- Both requesters valid continuously, 4 ops -> grants alternate 0,1,0,1 after reset. rsp_id follows the same order, with exactly ALU_LAT+3 cycles between strobes.
- Requester 1 valid while an operation is in WAIT -> req_ready stays 2'b00 until IDLE, then requester 1 is granted. No request is lost or duplicated.
- rst_n=0 asserted during WAIT -> no rsp_valid; all outputs 0 at the next edge; pointer=0. The first request after reset completes normally.
- ALU_LAT=0 with a combinational ALU model, OP_SLT a=3, b=9 -> rsp_c=1, with rsp_valid in the cycle after E1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-client ALU arbiter: opcodes, FSM encoding and default width.
package alu_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Subtract-style ops invert B and inject a carry; bit 2 of the opcode encodes both.
    function automatic logic op_b_invert(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU-side and response signals between the arbiter and its surroundings.
// Handshake: a request from client i is accepted at a rising edge where req_valid[i] & req_ready[i];
// the response is a single-cycle rsp_valid strobe with no backpressure.
interface alu_arbiter_if #(
    parameter int WIDTH = alu_pkg::DEF_WIDTH
);
    import alu_pkg::*;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2:0]       req_op0;
    logic [2:0]       req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;

    logic [2:0]       alu_operation;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_b_invert;
    logic             alu_carry_in;
    logic [WIDTH-1:0] alu_c;
    logic             alu_zero;
    logic             alu_overflow;
    logic             alu_carry_out;

    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_c;
    logic             rsp_zero;
    logic             rsp_overflow;
    logic             rsp_carry;

    logic             busy;
    state_t           dbg_state;

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
        input  alu_c, alu_zero, alu_overflow, alu_carry_out,
        output req_ready,
        output alu_operation, alu_a, alu_b, alu_b_invert, alu_carry_in,
        output rsp_valid, rsp_id, rsp_c, rsp_zero, rsp_overflow, rsp_carry,
        output busy, dbg_state
    );

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
        output alu_c, alu_zero, alu_overflow, alu_carry_out,
        input  req_ready,
        input  alu_operation, alu_a, alu_b, alu_b_invert, alu_carry_in,
        input  rsp_valid, rsp_id, rsp_c, rsp_zero, rsp_overflow, rsp_carry,
        input  busy, dbg_state
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer moves to the other client whenever a grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_grant
);

    logic       r_ptr;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    // Granting client 0 hands priority to client 1 and vice versa.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (|(i_req & w_grant)) begin
            r_ptr <= w_grant[0];
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two clients: arbitrate, latch operands, wait ALU_LAT edges,
// then return the captured result as a one-cycle tagged response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    localparam logic [2:0] LAT_CNT = 3'(ALU_LAT);

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic             r_owner;
    logic [2:0]       r_alu_op;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_b_invert;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_c;
    logic             r_rsp_zero;
    logic             r_rsp_ovf;
    logic             r_rsp_carry;

    logic [1:0]       w_grant;
    logic             w_idle;
    logic             w_accept;
    logic             w_sel;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    assign w_idle   = rst_n && (r_state == IDLE);
    assign w_accept = |(bus.req_valid & w_grant);
    assign w_sel    = w_grant[1];
    assign w_op     = w_sel ? bus.req_op1 : bus.req_op0;
    assign w_a      = w_sel ? bus.req_a1  : bus.req_a0;
    assign w_b      = w_sel ? bus.req_b1  : bus.req_b0;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (bus.req_valid),
        .i_en    (w_idle),
        .o_grant (w_grant)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_owner     <= 1'b0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_b_invert  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_c     <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_op   <= w_op;
                        r_alu_a    <= w_a;
                        r_alu_b    <= w_b;
                        r_b_invert <= op_b_invert(w_op);
                        r_owner    <= w_sel;
                        r_cnt      <= '0;
                        r_state    <= WAIT;
                    end
                end
                // Operands stay frozen here so the ALU sees stable inputs for ALU_LAT edges.
                WAIT: begin
                    if (r_cnt == LAT_CNT) begin
                        r_rsp_c     <= bus.alu_c;
                        r_rsp_zero  <= bus.alu_zero;
                        r_rsp_ovf   <= bus.alu_overflow;
                        r_rsp_carry <= bus.alu_carry_out;
                        r_rsp_id    <= r_owner;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = w_grant;
    assign bus.alu_operation = r_alu_op;
    assign bus.alu_a         = r_alu_a;
    assign bus.alu_b         = r_alu_b;
    assign bus.alu_b_invert  = r_b_invert;
    assign bus.alu_carry_in  = r_b_invert;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_id        = r_rsp_id;
    assign bus.rsp_c         = r_rsp_c;
    assign bus.rsp_zero      = r_rsp_zero;
    assign bus.rsp_overflow  = r_rsp_ovf;
    assign bus.rsp_carry     = r_rsp_carry;
    assign bus.busy          = (r_state != IDLE);
    assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one instance with a combinational ALU (ALU_LAT=0), one with a registered ALU (ALU_LAT=1).
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic           d_rst_n [2];
    logic [1:0]     d_valid [2];
    logic [2:0]     d_op    [2][2];
    logic [W-1:0]   d_a     [2][2];
    logic [W-1:0]   d_b     [2][2];
    wire  [3:0]     w_ready_all;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ALU behaviour seen by the arbiter: B optionally inverted, carry injected, op[1:0] selects AND/OR/ADD/SLT.
    function automatic logic [W+2:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic binv, input logic cin);
        logic [W-1:0] bb;
        logic [W-1:0] c;
        logic [W:0]   s;
        logic         ov;
        bb = binv ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
        ov = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        case (op[1:0])
            2'b00:   c = a & bb;
            2'b01:   c = a | bb;
            2'b10:   c = s[W-1:0];
            default: c = {{(W-1){1'b0}}, s[W-1] ^ ov};
        endcase
        return {(c == '0), ov, s[W], c};
    endfunction

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- DUTs, ALU models, scoreboards ----------------
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = g;

        alu_arbiter_if #(.WIDTH(W)) bus ();

        assign bus.req_valid = d_valid[g];
        assign bus.req_op0   = d_op[g][0];
        assign bus.req_op1   = d_op[g][1];
        assign bus.req_a0    = d_a[g][0];
        assign bus.req_a1    = d_a[g][1];
        assign bus.req_b0    = d_b[g][0];
        assign bus.req_b1    = d_b[g][1];
        assign w_ready_all[2*g +: 2] = bus.req_ready;

        logic [W+2:0] w_alu_now;
        assign w_alu_now = alu_fn(bus.alu_operation, bus.alu_a, bus.alu_b, bus.alu_b_invert, bus.alu_carry_in);

        if (LAT == 0) begin : g_comb
            assign {bus.alu_zero, bus.alu_overflow, bus.alu_carry_out, bus.alu_c} = w_alu_now;
        end else begin : g_reg
            logic [W+2:0] r_alu_q;
            always @(posedge clk) r_alu_q <= w_alu_now;
            assign {bus.alu_zero, bus.alu_overflow, bus.alu_carry_out, bus.alu_c} = r_alu_q;
        end

        alu_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) dut (
            .clk   (clk),
            .rst_n (d_rst_n[g]),
            .bus   (bus.slave)
        );

        // Reference: one op in flight, busy for LAT+2 sampled cycles after a grant, strobe in the last one.
        logic [W+3:0] exp_q [$];
        int           m_left = 0;
        logic         m_ptr = 1'b0;
        logic         m_zero_chk = 1'b0;
        logic [2:0]   m_op = '0;
        logic [W-1:0] m_a = '0;
        logic [W-1:0] m_b = '0;
        logic [1:0]   m_ready;

        int           n_strobe = 0;
        int           last_t = 0;
        logic [W-1:0] last_c = '0;
        logic         last_zero = 1'b0;
        logic         last_id = 1'b0;
        int           strobe_t  [64];
        logic         strobe_id [64];

        always_comb begin
            m_ready = 2'b00;
            if (m_left == 0 && d_rst_n[g]) begin
                if (d_valid[g] == 2'b11) m_ready = m_ptr ? 2'b10 : 2'b01;
                else                     m_ready = d_valid[g];
            end
        end

        always @(negedge clk) begin
            if (m_zero_chk) begin
                check($sformatf("i%0d_reset_alu", g), 128'({bus.alu_operation, bus.alu_a, bus.alu_b,
                      bus.alu_b_invert, bus.alu_carry_in}), 128'(0));
                check($sformatf("i%0d_reset_rsp", g), 128'({bus.rsp_valid, bus.rsp_id, bus.rsp_c,
                      bus.rsp_zero, bus.rsp_overflow, bus.rsp_carry}), 128'(0));
            end
            check($sformatf("i%0d_ready", g), 128'(bus.req_ready), 128'(m_ready));
            check($sformatf("i%0d_busy", g), 128'(bus.busy), 128'(m_left > 0));
            check($sformatf("i%0d_rsp_valid", g), 128'(bus.rsp_valid), 128'(m_left == 1));
            if (m_left > 0)
                check($sformatf("i%0d_alu_drive", g),
                      128'({bus.alu_operation, bus.alu_a, bus.alu_b, bus.alu_b_invert, bus.alu_carry_in}),
                      128'({m_op, m_a, m_b, m_op[2], m_op[2]}));
            if (m_left == 1 && exp_q.size() > 0)
                check($sformatf("i%0d_rsp", g),
                      128'({bus.rsp_id, bus.rsp_zero, bus.rsp_overflow, bus.rsp_carry, bus.rsp_c}),
                      128'(exp_q.pop_front()));
            if (bus.rsp_valid) begin
                strobe_t[n_strobe % 64]  <= cyc;
                strobe_id[n_strobe % 64] <= bus.rsp_id;
                n_strobe  <= n_strobe + 1;
                last_t    <= cyc;
                last_c    <= bus.rsp_c;
                last_zero <= bus.rsp_zero;
                last_id   <= bus.rsp_id;
            end
            if (!d_rst_n[g]) begin
                m_left     <= 0;
                m_ptr      <= 1'b0;
                m_zero_chk <= 1'b1;
                exp_q.delete();
            end else begin
                m_zero_chk <= 1'b0;
                if (m_left > 0) begin
                    m_left <= m_left - 1;
                end else if (m_ready != 2'b00) begin
                    m_op   <= d_op[g][m_ready[1]];
                    m_a    <= d_a[g][m_ready[1]];
                    m_b    <= d_b[g][m_ready[1]];
                    m_ptr  <= ~m_ready[1];
                    m_left <= LAT + 2;
                    exp_q.push_back({m_ready[1], alu_fn(d_op[g][m_ready[1]], d_a[g][m_ready[1]],
                                     d_b[g][m_ready[1]], d_op[g][m_ready[1]][2], d_op[g][m_ready[1]][2])});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic new_req(input int d, input int r);
        d_op[d][r]    = 3'($urandom_range(0, 7));
        d_a[d][r]     = pick_val();
        d_b[d][r]     = pick_val();
        d_valid[d][r] = 1'b1;
    endtask

    task automatic send(input int d, input int r, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        logic ok;
        ok = 1'b0;
        d_op[d][r]    = op;
        d_a[d][r]     = a;
        d_b[d][r]     = b;
        d_valid[d][r] = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = w_ready_all[2*d + r];
            @(posedge clk);
            #1;
        end
        d_valid[d][r] = 1'b0;
        check($sformatf("send_i%0d_r%0d", d, r), 128'(ok), 128'(1));
    endtask

    task automatic do_reset(input int d);
        @(posedge clk);
        #1;
        d_rst_n[d] = 1'b0;
        d_valid[d] = 2'b00;
        @(posedge clk);
        #1;
        d_rst_n[d] = 1'b1;
    endtask

    task automatic rand_cycles(input int n);
        logic [1:0] acc [2];
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) acc[d] = d_valid[d] & w_ready_all[2*d +: 2];
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (!d_rst_n[d]) begin
                    d_rst_n[d] = 1'b1;
                end else if ($urandom_range(0, 399) == 0) begin
                    d_rst_n[d] = 1'b0;
                    d_valid[d] = 2'b00;
                end else begin
                    for (int r = 0; r < 2; r++) begin
                        if (d_valid[d][r] && !acc[d][r]) begin
                            if ($urandom_range(0, 19) == 0) d_valid[d][r] = 1'b0;
                        end else if ($urandom_range(0, 2) != 0) begin
                            new_req(d, r);
                        end else begin
                            d_valid[d][r] = 1'b0;
                        end
                    end
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc_cyc;
        int base;
        int cnt;
        int wait_k;
        logic [W-1:0] ta;
        logic [W-1:0] tb;

        for (int d = 0; d < 2; d++) begin
            d_rst_n[d] = 1'b0;
            d_valid[d] = 2'b00;
            for (int r = 0; r < 2; r++) begin
                d_op[d][r] = '0;
                d_a[d][r]  = '0;
                d_b[d][r]  = '0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        d_rst_n[0] = 1'b1;
        d_rst_n[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ADD 5+7 from client 0 through the registered ALU
        send(1, 0, OP_ADD, 32'd5, 32'd7);
        acc_cyc = cyc;
        check("add_b_invert", 128'(g_dut[1].bus.alu_b_invert), 128'(0));
        repeat (4) @(posedge clk);
        #1;
        check("add_c", 128'(g_dut[1].last_c), 128'(32'd12));
        check("add_zero", 128'(g_dut[1].last_zero), 128'(0));
        check("add_id", 128'(g_dut[1].last_id), 128'(0));
        check("add_latency", 128'(g_dut[1].last_t - acc_cyc), 128'(2));

        // SUB all-ones minus all-ones from client 1
        send(1, 1, OP_SUB, '1, '1);
        check("sub_b_invert", 128'(g_dut[1].bus.alu_b_invert), 128'(1));
        check("sub_carry_in", 128'(g_dut[1].bus.alu_carry_in), 128'(1));
        repeat (4) @(posedge clk);
        #1;
        check("sub_c", 128'(g_dut[1].last_c), 128'(0));
        check("sub_zero", 128'(g_dut[1].last_zero), 128'(1));
        check("sub_id", 128'(g_dut[1].last_id), 128'(1));

        // Both clients held valid: four grants alternate starting at client 0
        do_reset(1);
        base = g_dut[1].n_strobe;
        d_op[1][0] = OP_ADD; d_a[1][0] = 32'd10; d_b[1][0] = 32'd1;
        d_op[1][1] = OP_OR;  d_a[1][1] = 32'hF0; d_b[1][1] = 32'h0F;
        d_valid[1] = 2'b11;
        cnt = 0;
        for (int k = 0; k < 80 && cnt < 4; k++) begin
            @(negedge clk);
            if (w_ready_all[3:2] != 2'b00) cnt++;
            @(posedge clk);
            #1;
        end
        d_valid[1] = 2'b00;
        check("rr_accepts", 128'(cnt), 128'(4));
        repeat (6) @(posedge clk);
        #1;
        check("rr_strobes", 128'(g_dut[1].n_strobe - base), 128'(4));
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_id%0d", i), 128'(g_dut[1].strobe_id[(base + i) % 64]), 128'(i % 2));
        for (int i = 1; i < 4; i++)
            check($sformatf("rr_gap%0d", i), 128'(g_dut[1].strobe_t[(base + i) % 64]
                  - g_dut[1].strobe_t[(base + i - 1) % 64]), 128'(4));

        // Client 1 arrives while an op is in WAIT: it is granted only once IDLE returns
        send(1, 0, OP_AND, 32'hFF00, 32'h0FF0);
        base = g_dut[1].n_strobe;
        d_op[1][1] = OP_ADD; d_a[1][1] = 32'd1; d_b[1][1] = 32'd2;
        d_valid[1][1] = 1'b1;
        wait_k = -1;
        for (int k = 0; k < 20 && wait_k < 0; k++) begin
            @(negedge clk);
            if (w_ready_all[3:2] == 2'b10) wait_k = k;
            @(posedge clk);
            #1;
        end
        d_valid[1][1] = 1'b0;
        check("late_grant_delay", 128'(wait_k), 128'(3));
        repeat (6) @(posedge clk);
        #1;
        check("late_no_dup", 128'(g_dut[1].n_strobe - base), 128'(2));
        check("late_id", 128'(g_dut[1].last_id), 128'(1));
        check("late_c", 128'(g_dut[1].last_c), 128'(32'd3));

        // Reset while in WAIT drops the op; pointer returns to client 0
        send(1, 1, OP_ADD, 32'd1, 32'd2);
        base = g_dut[1].n_strobe;
        d_rst_n[1] = 1'b0;
        @(posedge clk);
        #1;
        d_rst_n[1] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_drop", 128'(g_dut[1].n_strobe - base), 128'(0));
        d_op[1][0] = OP_ADD; d_a[1][0] = 32'd100; d_b[1][0] = 32'd23;
        d_op[1][1] = OP_SUB; d_a[1][1] = 32'd9;   d_b[1][1] = 32'd4;
        d_valid[1] = 2'b11;
        @(negedge clk);
        check("reset_ptr", 128'(w_ready_all[3:2]), 128'(2'b01));
        @(posedge clk);
        #1;
        d_valid[1] = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        check("reset_first_cnt", 128'(g_dut[1].n_strobe - base), 128'(1));
        check("reset_first_c", 128'(g_dut[1].last_c), 128'(32'd123));

        // Combinational ALU: SLT 3 < 9
        send(0, 0, OP_SLT, 32'd3, 32'd9);
        acc_cyc = cyc;
        repeat (4) @(posedge clk);
        #1;
        check("slt_c", 128'(g_dut[0].last_c), 128'(32'd1));
        check("slt_latency", 128'(g_dut[0].last_t - acc_cyc), 128'(1));

        // Opcode outside the list: passed through with B inverted
        ta = 32'hF0F0_1234;
        tb = 32'hFF00_FF00;
        send(1, 1, 3'b100, ta, tb);
        check("odd_op_binv", 128'(g_dut[1].bus.alu_b_invert), 128'(1));
        check("odd_op_pass", 128'(g_dut[1].bus.alu_operation), 128'(3'b100));
        repeat (4) @(posedge clk);
        #1;
        check("odd_op_c", 128'(g_dut[1].last_c), 128'(ta & ~tb));

        // Random traffic on both instances, scored by the per-instance reference
        rand_cycles(3000);
        d_valid[0] = 2'b00;
        d_valid[1] = 2'b00;
        d_rst_n[0] = 1'b1;
        d_rst_n[1] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("drain_i0", 128'(g_dut[0].exp_q.size()), 128'(0));
        check("drain_i1", 128'(g_dut[1].exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
